wb_arbiter_2m: RTL and testbench

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

---
 rtl/wb_arbiter_2m.sv | 178 +++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// ============================================================================
// Module   : wb_arbiter_2m
// Purpose  : Two-master Wishbone arbiter with round-robin tie-break and a
//            per-transfer bus-timeout that terminates stalled cycles with err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,

  output logic [1:0]  owner_o,
  output logic        timeout_o
);

  // State encoding doubles as the owner_o code (00 none, 01 m0, 10 m1)
  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_GNT0  = 2'b01;
  localparam logic [1:0] C_GNT1  = 2'b10;
  localparam logic [7:0] C_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] C_CMAX  = 8'hFF;

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;   // 0: m0 owned last, 1: m1 owned last
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       gnt0;
  logic       gnt1;
  logic       granted;
  logic       timeout_hit;

  assign gnt0    = (state_q == C_GNT0);
  assign gnt1    = (state_q == C_GNT1);
  assign granted = gnt0 | gnt1;

  // Slave-side request mux
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (state_q)
      C_GNT0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
      end
      C_GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
      end
      default: ;
    endcase
  end

  // A slave ack on the limit cycle wins over the timeout
  assign timeout_hit = granted && s_cyc_o && s_stb_o && !s_ack_i && !s_err_i
                       && (wait_cnt_q == C_LIMIT);
  assign timeout_o   = timeout_hit;

  // Master-side response demux
  always_comb begin
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (gnt0) begin
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i | timeout_hit;
    end
    if (gnt1) begin
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i | timeout_hit;
    end
  end

  assign owner_o = state_q;

  // Arbitration looks at cyc only; stb never influences the grant
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      C_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_owner_q ? C_GNT0 : C_GNT1;
        end else if (m0_cyc_i) begin
          state_d = C_GNT0;
        end else if (m1_cyc_i) begin
          state_d = C_GNT1;
        end
      end
      C_GNT0: begin
        if (!m0_cyc_i) begin
          state_d      = C_IDLE;
          last_owner_d = 1'b0;
        end
      end
      C_GNT1: begin
        if (!m1_cyc_i) begin
          state_d      = C_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!granted || !s_cyc_o || !s_stb_o || s_ack_i || s_err_i || timeout_hit) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != C_CMAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= C_IDLE;
      last_owner_q <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// ============================================================================
// Module   : tb_wb_arbiter_2m
// Purpose  : Directed plus randomized self-checking bench for wb_arbiter_2m.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter_2m;

  localparam int T = 16;

  logic        clk;
  logic        reset_n;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]  owner_o;
  logic        timeout_o;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, who owned it last, and how many
  // consecutive unanswered strobe cycles the current owner has accumulated.
  int owner_m = 0;   // 0 none, 1 m0, 2 m1
  int last_m  = 2;
  int stall_m = 0;

  // Values sampled at the most recent check point
  logic [1:0] smp_owner;
  logic smp_scyc, smp_sstb, smp_ack0, smp_ack1, smp_err1, smp_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_timeout();
    logic c, s;
    c = (owner_m == 1) ? m0_cyc_i : (owner_m == 2) ? m1_cyc_i : 1'b0;
    s = (owner_m == 1) ? m0_stb_i : (owner_m == 2) ? m1_stb_i : 1'b0;
    return c && s && !s_ack_i && !s_err_i && (stall_m == T - 1);
  endfunction

  task automatic check_all();
    logic to;
    to = exp_timeout();
    chk("owner", 32'(owner_o), 32'(owner_m));
    chk("s_cyc", 32'(s_cyc_o), 32'((owner_m == 1) ? m0_cyc_i : (owner_m == 2) ? m1_cyc_i : 1'b0));
    chk("s_stb", 32'(s_stb_o), 32'((owner_m == 1) ? m0_stb_i : (owner_m == 2) ? m1_stb_i : 1'b0));
    chk("s_we",  32'(s_we_o),  32'((owner_m == 1) ? m0_we_i  : (owner_m == 2) ? m1_we_i  : 1'b0));
    chk("s_adr", s_adr_o, (owner_m == 1) ? m0_adr_i : (owner_m == 2) ? m1_adr_i : 32'h0);
    chk("s_dat", s_dat_o, (owner_m == 1) ? m0_dat_i : (owner_m == 2) ? m1_dat_i : 32'h0);
    chk("s_sel", 32'(s_sel_o), 32'((owner_m == 1) ? m0_sel_i : (owner_m == 2) ? m1_sel_i : 4'h0));
    chk("m0_dat", m0_dat_o, (owner_m == 1) ? s_dat_i : 32'h0);
    chk("m1_dat", m1_dat_o, (owner_m == 2) ? s_dat_i : 32'h0);
    chk("m0_ack", 32'(m0_ack_o), 32'((owner_m == 1) && s_ack_i));
    chk("m1_ack", 32'(m1_ack_o), 32'((owner_m == 2) && s_ack_i));
    chk("m0_err", 32'(m0_err_o), 32'((owner_m == 1) && (s_err_i || to)));
    chk("m1_err", 32'(m1_err_o), 32'((owner_m == 2) && (s_err_i || to)));
    chk("timeout", 32'(timeout_o), 32'(to));
  endtask

  task automatic model_edge();
    logic c, s, to;
    c  = (owner_m == 1) ? m0_cyc_i : (owner_m == 2) ? m1_cyc_i : 1'b0;
    s  = (owner_m == 1) ? m0_stb_i : (owner_m == 2) ? m1_stb_i : 1'b0;
    to = exp_timeout();
    if (!reset_n) begin
      owner_m = 0; last_m = 2; stall_m = 0;
    end else begin
      if (owner_m == 0 || !c || !s || s_ack_i || s_err_i || to) stall_m = 0;
      else if (stall_m < 255) stall_m++;
      if (owner_m == 0) begin
        if (m0_cyc_i && m1_cyc_i) owner_m = (last_m == 2) ? 1 : 2;
        else if (m0_cyc_i)        owner_m = 1;
        else if (m1_cyc_i)        owner_m = 2;
      end else if (!c) begin
        last_m  = owner_m;
        owner_m = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    smp_owner = owner_o;  smp_scyc = s_cyc_o;  smp_sstb = s_stb_o;
    smp_ack0  = m0_ack_o; smp_ack1 = m1_ack_o; smp_err1 = m1_err_o;
    smp_to    = timeout_o;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    m0_sel_i = 4'hF;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    m1_sel_i = 4'h3;
  endtask

  initial begin
    int n;
    int acks;
    reset_n = 1'b0;
    set_m0(0, 0, 0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 32'h0, 32'h0);
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;
    #1;
    cycle(); cycle();
    chk("reset_owner", 32'(smp_owner), 32'd0);
    chk("reset_scyc", 32'(smp_scyc), 32'd0);
    reset_n = 1'b1;

    // m0 alone: write with slave ack two cycles into the grant
    set_m0(1, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF);
    acks = 0;
    cycle();                                   // IDLE, arbitration latency
    cycle(); acks += int'(smp_ack0);           // granted, waiting
    chk("m0_grant", 32'(smp_owner), 32'd1);
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    cycle(); acks += int'(smp_ack0);
    s_ack_i = 1'b0;
    set_m0(0, 0, 0, 32'h0, 32'h0);
    cycle(); acks += int'(smp_ack0);
    cycle(); acks += int'(smp_ack0);
    chk("m0_ack_count", 32'(acks), 32'd1);
    chk("m0_release", 32'(smp_owner), 32'd0);

    // Tie straight from reset: m0 first, then m1 after one IDLE cycle
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    set_m0(1, 1, 0, 32'h0000_0200, 32'h0);
    set_m1(1, 1, 1, 32'h0000_0300, 32'hCAFE_F00D);
    cycle();
    cycle(); chk("tie1_m0", 32'(smp_owner), 32'd1);
    cycle();
    set_m0(0, 0, 0, 32'h0, 32'h0);
    cycle(); chk("tie1_m0_drop", 32'(smp_owner), 32'd1);
    cycle(); chk("tie1_idle", 32'(smp_owner), 32'd0);
    s_ack_i = 1'b1;
    cycle(); chk("tie1_m1", 32'(smp_owner), 32'd2);
    chk("tie1_m1_ack", 32'(smp_ack1), 32'd1);
    s_ack_i = 1'b0;
    set_m1(0, 0, 0, 32'h0, 32'h0);
    cycle();
    // Second tie right after the m1 transfer goes back to m0
    set_m0(1, 1, 1, 32'h0000_0400, 32'h1111_2222);
    set_m1(1, 1, 0, 32'h0000_0500, 32'h0);
    cycle(); chk("tie2_idle", 32'(smp_owner), 32'd0);
    cycle(); chk("tie2_m0", 32'(smp_owner), 32'd1);
    set_m0(0, 0, 0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 32'h0, 32'h0);
    cycle(); cycle();

    // m1 read with no slave answer: timeout on the 16th strobe cycle
    set_m1(1, 1, 0, 32'h0000_0600, 32'h0);
    cycle();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (smp_sstb) n++;
      if (smp_err1) break;
    end
    chk("timeout_latency", 32'(n), 32'(T));
    chk("timeout_pulse", 32'(smp_to), 32'd1);
    cycle();
    chk("timeout_width", 32'(smp_to), 32'd0);

    // Ack arriving exactly on the limit cycle wins over the timeout
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (stall_m == T - 1) s_ack_i = 1'b1;
      cycle();
      n++;
      if (s_ack_i) break;
    end
    chk("limit_ack", 32'(smp_ack1), 32'd1);
    chk("limit_err", 32'(smp_err1), 32'd0);
    chk("limit_to", 32'(smp_to), 32'd0);
    s_ack_i = 1'b0;
    cycle(); cycle();

    // One-edge reset during a granted m1 wait aborts without err
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    set_m0(1, 1, 1, 32'h0000_0700, 32'h0);
    cycle();
    chk("rst_owner", 32'(smp_owner), 32'd0);
    chk("rst_scyc", 32'(smp_scyc), 32'd0);
    cycle();
    chk("rst_tie_m0", 32'(smp_owner), 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_we_i  = 1'($urandom); m1_we_i = 1'($urandom);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom);
      s_dat_i  = $urandom;
      s_ack_i  = ($urandom_range(0, 19) == 0);
      s_err_i  = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
